// File: rtl/qed_trace_dump_ctrl.sv
// Dump sequencer for the two-lane QED trace buffers: mirrors fill levels while armed, then streams lane 1 then lane 2 oldest-first.
// Latency: first beat 2 cycles after the fault&&dump_en sample; backpressure: out_* held while out_valid && !out_ready, 1 beat/cycle otherwise.
module qed_trace_dump_ctrl #(
    parameter  int FIFO_SIZE = 16,
    parameter  int PKT_W     = 64,
    localparam int AW        = $clog2(FIFO_SIZE),
    localparam int FW        = $clog2(FIFO_SIZE + 1)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            wr1_valid,
    input  logic                            wr2_valid,
    input  logic                            fault_latched,
    input  logic [AW-1:0]                   head1,
    input  logic [AW-1:0]                   head2,
    input  logic [FIFO_SIZE-1:0][PKT_W-1:0] trace1,
    input  logic [FIFO_SIZE-1:0][PKT_W-1:0] trace2,
    input  logic                            dump_en,
    input  logic                            out_ready,
    output logic                            out_valid,
    output logic                            out_sel,
    output logic [AW-1:0]                   out_idx,
    output logic [PKT_W-1:0]                out_pkt,
    output logic                            out_last,
    output logic                            busy,
    output logic                            done
);

    typedef enum logic [1:0] {ARMED, LOAD, DUMP, DONE} state_t;

    localparam logic [FW:0]   FS_X    = (FW + 1)'(FIFO_SIZE);
    localparam logic [FW-1:0] FS_FILL = FW'(FIFO_SIZE);
    localparam logic [AW-1:0] POS_MAX = AW'(FIFO_SIZE - 1);

    state_t        r_state;
    logic [FW-1:0] r_fill1;
    logic [FW-1:0] r_fill2;
    logic [AW-1:0] r_start2;
    logic [AW-1:0] r_pos;
    logic [AW-1:0] r_k;
    logic          r_lane;

    logic [FW:0]   w_h1x;
    logic [FW:0]   w_h2x;
    logic [FW:0]   w_s1x;
    logic [FW:0]   w_s2x;
    logic [AW-1:0] w_start1;
    logic [AW-1:0] w_start2;
    logic [AW-1:0] w_pos_inc;
    logic [FW-1:0] w_lane_fill;
    logic          w_lane_end;
    logic          w_beat_last;
    logic          w_unused;

    // Oldest entry sits fill slots behind the write pointer, modulo FIFO_SIZE (need not be a power of two).
    assign w_h1x    = (FW + 1)'(head1);
    assign w_h2x    = (FW + 1)'(head2);
    assign w_s1x    = (w_h1x >= {1'b0, r_fill1}) ? w_h1x - {1'b0, r_fill1}
                                                  : w_h1x + FS_X - {1'b0, r_fill1};
    assign w_s2x    = (w_h2x >= {1'b0, r_fill2}) ? w_h2x - {1'b0, r_fill2}
                                                  : w_h2x + FS_X - {1'b0, r_fill2};
    assign w_start1 = w_s1x[AW-1:0];
    assign w_start2 = w_s2x[AW-1:0];
    assign w_unused = ^{w_s1x[FW:AW], w_s2x[FW:AW]};

    assign w_pos_inc   = (r_pos == POS_MAX) ? '0 : r_pos + AW'(1);
    assign w_lane_fill = r_lane ? r_fill2 : r_fill1;
    assign w_lane_end  = (FW'(r_k) == w_lane_fill - FW'(1));
    assign w_beat_last = w_lane_end && (r_lane || (r_fill2 == '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ARMED;
            r_fill1   <= '0;
            r_fill2   <= '0;
            r_start2  <= '0;
            r_pos     <= '0;
            r_k       <= '0;
            r_lane    <= 1'b0;
            out_valid <= 1'b0;
            out_sel   <= 1'b0;
            out_idx   <= '0;
            out_pkt   <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (r_state)
                ARMED: begin
                    // A write coinciding with the fault is not counted: the buffer does not store it.
                    if (wr1_valid && !fault_latched && (r_fill1 != FS_FILL))
                        r_fill1 <= r_fill1 + FW'(1);
                    if (wr2_valid && !fault_latched && (r_fill2 != FS_FILL))
                        r_fill2 <= r_fill2 + FW'(1);
                    if (fault_latched && dump_en) begin
                        r_state <= LOAD;
                        busy    <= 1'b1;
                    end
                end
                LOAD: begin
                    r_start2 <= w_start2;
                    r_k      <= '0;
                    if (r_fill1 != '0) begin
                        r_lane  <= 1'b0;
                        r_pos   <= w_start1;
                        r_state <= DUMP;
                    end else if (r_fill2 != '0) begin
                        r_lane  <= 1'b1;
                        r_pos   <= w_start2;
                        r_state <= DUMP;
                    end else begin
                        r_state <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                DUMP: begin
                    if (!out_valid || out_ready) begin
                        if (out_valid && out_last) begin
                            r_state   <= DONE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            out_valid <= 1'b1;
                            out_pkt   <= r_lane ? trace2[r_pos] : trace1[r_pos];
                            out_idx   <= r_k;
                            out_sel   <= r_lane;
                            out_last  <= w_beat_last;
                            // Lane 1 exhausted: jump straight to lane 2 so there is no bubble.
                            if (w_lane_end && !r_lane) begin
                                r_lane <= 1'b1;
                                r_k    <= '0;
                                r_pos  <= r_start2;
                            end else begin
                                r_k    <= r_k + AW'(1);
                                r_pos  <= w_pos_inc;
                            end
                        end
                    end
                end
                DONE: begin
                    r_state <= DONE;
                end
                default: begin
                    r_state <= ARMED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qed_trace_dump_ctrl.sv
// Directed bench for qed_trace_dump_ctrl with FIFO_SIZE=4: stimulus pushes expected beats, a negedge monitor checks them.
module tb_qed_trace_dump_ctrl;

    localparam int FS = 4;
    localparam int PW = 16;

    typedef struct packed {
        logic          sel;
        logic [1:0]    idx;
        logic [PW-1:0] pkt;
        logic          last;
    } beat_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 wr1_valid, wr2_valid, fault_latched, dump_en, out_ready;
    logic [1:0]           head1, head2;
    logic [FS-1:0][PW-1:0] trace1, trace2;
    logic                 out_valid, out_sel, out_last, busy, done;
    logic [1:0]           out_idx;
    logic [PW-1:0]        out_pkt;

    beat_t sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    qed_trace_dump_ctrl #(.FIFO_SIZE(FS), .PKT_W(PW)) dut (
        .clk(clk), .reset(reset),
        .wr1_valid(wr1_valid), .wr2_valid(wr2_valid), .fault_latched(fault_latched),
        .head1(head1), .head2(head2), .trace1(trace1), .trace2(trace2),
        .dump_en(dump_en), .out_ready(out_ready),
        .out_valid(out_valid), .out_sel(out_sel), .out_idx(out_idx), .out_pkt(out_pkt),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: a presented beat must match the queue head; held beats are rechecked every stalled cycle.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_beat: got sel=%0d idx=%0d pkt=%h last=%0d, required no beat",
                         out_sel, out_idx, out_pkt, out_last);
            end else begin
                if ({out_sel, out_idx, out_pkt, out_last} !== sb[0]) begin
                    n_fail++;
                    $display("FAIL beat: got sel=%0d idx=%0d pkt=%h last=%0d, required sel=%0d idx=%0d pkt=%h last=%0d",
                             out_sel, out_idx, out_pkt, out_last,
                             sb[0].sel, sb[0].idx, sb[0].pkt, sb[0].last);
                end
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic sel, input logic [1:0] idx, input logic [PW-1:0] pkt, input logic last);
        beat_t b;
        b.sel = sel; b.idx = idx; b.pkt = pkt; b.last = last;
        sb.push_back(b);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        wr1_valid = 1'b0; wr2_valid = 1'b0;
        fault_latched = 1'b0; dump_en = 1'b0; out_ready = 1'b1;
        head1 = '0; head2 = '0;
        sb.delete();
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic write(input int lane);
        if (lane == 1) wr1_valid = 1'b1; else wr2_valid = 1'b1;
        tick;
        wr1_valid = 1'b0; wr2_valid = 1'b0;
        if (lane == 1) head1 = head1 + 2'd1; else head2 = head2 + 2'd1;
    endtask

    task automatic trigger;
        fault_latched = 1'b1;
        dump_en       = 1'b1;
    endtask

    task automatic wait_done(input string name, input int exp_ticks);
        int n = 0;
        while (!done && n < 60) begin
            tick;
            n++;
        end
        check({name, "_done_latency"}, n, exp_ticks);
        check({name, "_busy_after"}, busy, 0);
        check({name, "_valid_after"}, out_valid, 0);
        check({name, "_beats_drained"}, sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required finish before 200000");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < FS; i++) begin
            trace1[i] = PW'(16'hA100 + i);
            trace2[i] = PW'(16'hB200 + i);
        end

        // Reset state
        do_reset;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pkt", out_pkt, 0);
        check("rst_last", out_last, 0);
        check("rst_sel_idx", {out_sel, out_idx}, 0);

        // Two lanes, no wrap: (0,0)(0,1)(1,0)(1,1)(1,2)
        write(1); write(1);
        write(2); write(2); write(2);
        push(0, 0, 16'hA100, 0); push(0, 1, 16'hA101, 0);
        push(1, 0, 16'hB200, 0); push(1, 1, 16'hB201, 0); push(1, 2, 16'hB202, 1);
        trigger;
        tick;
        check("t1_busy_load", busy, 1);
        check("t1_valid_load", out_valid, 0);
        tick;
        check("t1_valid_dump_entry", out_valid, 0);
        tick;
        check("t1_first_valid", out_valid, 1);
        wait_done("t1", 5);

        // Lane 1 wrapped and saturated, head1=2; lane 2 empty
        do_reset;
        for (int i = 0; i < 6; i++) write(1);
        check("t2_head1", head1, 2);
        push(0, 0, 16'hA102, 0); push(0, 1, 16'hA103, 0);
        push(0, 2, 16'hA100, 0); push(0, 3, 16'hA101, 1);
        trigger;
        wait_done("t2", 7);

        // Fault with no writes
        do_reset;
        trigger;
        wait_done("t3", 2);

        // Backpressure on beat 2 for three cycles
        do_reset;
        write(1); write(1); write(1);
        write(2);
        push(0, 0, 16'hA100, 0); push(0, 1, 16'hA101, 0);
        push(0, 2, 16'hA102, 0); push(1, 0, 16'hB200, 1);
        trigger;
        repeat (4) tick;
        out_ready = 1'b0;
        repeat (3) tick;
        check("t4_held_valid", out_valid, 1);
        check("t4_held_idx", out_idx, 1);
        out_ready = 1'b1;
        wait_done("t4", 3);

        // Fault without dump_en; writes alongside or after the fault are not counted
        do_reset;
        write(2);
        fault_latched = 1'b1;
        wr1_valid     = 1'b1;
        tick;
        wr1_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wr1_valid = (i == 4);
            tick;
            check("t5_busy_idle", busy, 0);
        end
        wr1_valid = 1'b0;
        check("t5_done_idle", done, 0);
        push(1, 0, 16'hB200, 1);
        dump_en = 1'b1;
        tick;
        check("t5_busy_load", busy, 1);
        wait_done("t5", 3);

        // Reset while a beat is stalled, then a fresh capture
        do_reset;
        write(1); write(1); write(1);
        out_ready = 1'b0;
        push(0, 0, 16'hA100, 0);
        trigger;
        repeat (3) tick;
        check("t6_valid_before_rst", out_valid, 1);
        reset = 1'b1;
        fault_latched = 1'b0; dump_en = 1'b0;
        head1 = '0; head2 = '0;
        sb.delete();
        tick;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_done", done, 0);
        check("t6_rst_pkt", out_pkt, 0);
        check("t6_rst_sel_idx_last", {out_sel, out_idx, out_last}, 0);
        reset = 1'b0;
        out_ready = 1'b1;
        write(2); write(2);
        push(1, 0, 16'hB200, 0); push(1, 1, 16'hB201, 1);
        trigger;
        wait_done("t6", 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
